escalonador_acoes: RTL and testbench
====================================

// Module: escalonador_acoes
// PURPOSE
//   Sequences the pet's activity: arbitrates the player's action requests (eat, sleep, teach)
//   and drives the one-hot 4-bit estado bus consumed by the attribute controller.
//   Each accepted action is held for a fixed number of clk cycles; one further request is buffered.
//   Watches fome/felicidade/sono and forces MORTO when any reaches zero; revive restarts the pet.
// PARAMETERS
//   DURACAO      = 1000000  clk cycles an accepted action stays active (>= 2)
//   LIMIAR_SONO  = 8'd10    sono at or below this forces DORMINDO from OCIOSO
//   ATTR_W       = 8        width of attribute inputs
// PORTS
//   clk          in   1       system clock
//   rst          in   1       synchronous, active-high reset
//   req_comer    in   1       request eat; level sampled each cycle
//   req_dormir   in   1       request sleep
//   req_aula     in   1       request teach
//   req_reviver  in   1       revive request; honoured only in MORTO
//   fome         in   ATTR_W  current hunger attribute
//   felicidade   in   ATTR_W  current happiness attribute
//   sono         in   ATTR_W  current rest attribute
//   estado       out  4       one-hot: 0001 DORMINDO, 0010 COMENDO, 0100 DANDO_AULA, 1000 MORTO,
//                             0000 OCIOSO
//   ocupado      out  1       1 while an action is active (estado[2:0] != 0)
//   pendente     out  1       1 while a buffered request is held
//   aceito       out  1       1-cycle pulse in the cycle a new action becomes active
//   reiniciar    out  1       1-cycle pulse on revive (MORTO -> OCIOSO)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): estado=0000, timer=0, buffer empty; ocupado, pendente, aceito and
//     reiniciar are 0. Reset overrides every other event, including reset mid-action and in MORTO.
//   - Death check runs first, every cycle outside MORTO: if fome==0, felicidade==0 or sono==0,
//     estado<=MORTO next cycle. The timer and buffer are cleared, and aceito is not pulsed.
//   - MORTO: requests are ignored and not buffered. req_reviver=1 -> estado<=OCIOSO and reiniciar=1
//     for that cycle. Revive beats the death check in that cycle.
//   - Arbitration priority for simultaneous requests: comer > dormir > aula. Lower requests that
//     cycle are dropped.
//   - OCIOSO, buffer empty: highest request -> that action next cycle, timer<=DURACAO-1, aceito=1.
//     If no request and sono<=LIMIAR_SONO -> DORMINDO, same timer and aceito rules.
//   - Active action: timer decrements each cycle. In the cycle timer==0 the action ends:
//     if a request is buffered, estado<=buffered action, timer<=DURACAO-1, aceito=1, buffer cleared;
//     otherwise estado<=OCIOSO.
//     The action is therefore visible exactly DURACAO cycles, with back-to-back actions gap-free.
//   - Request during an active action, buffer empty: the arbitrated request is stored and
//     pendente<=1. A request equal to the current action is still stored.
//   - Buffer full: further requests are dropped (first wins, no overwrite).
//   - A request arriving in the same cycle the timer hits 0 with an empty buffer is accepted
//     directly as the next action.
//   - aceito is never high in the same cycle as a death transition.
//   - The timer must be wide enough for DURACAO-1 (use $clog2); no wrap below 0.
// TESTING
//   (DURACAO=4, LIMIAR_SONO=10 on bench; attributes held at 50 unless stated)
//   1. rst high 2 cycles -> estado=0000, ocupado/pendente/aceito/reiniciar=0.
//   2. req_comer pulse 1 cycle -> estado=0010 for exactly 4 cycles with aceito on the first,
//      then 0000.
//   3. req_comer+req_dormir+req_aula same cycle -> estado=0010 only; no pendente.
//   4. Sequence:
//      - req_aula, then req_dormir 1 cycle later: 0100 x4, then 0001 x4 with no OCIOSO gap.
//      - A later req_comer while pendente=1 is dropped.
//   5. Death and revive:
//      - fome driven to 0 mid-DORMINDO -> 1000 next cycle, pendente cleared, req_comer ignored.
//      - req_reviver -> 0000 and a 1-cycle reiniciar.
//   6. In OCIOSO, sono=10 with no requests -> 0001 with aceito.
//      Assert rst while an action is active -> 0000 next cycle.

Source files
------------

// File: rtl/escalonador_acoes.sv
// Pet activity sequencer: arbitrates eat/sleep/teach requests, holds each action for
// DURACAO cycles with a one-deep request buffer, and forces MORTO when an attribute hits zero.
module escalonador_acoes #(
  parameter int                 DURACAO     = 1000000,
  parameter int                 ATTR_W      = 8,
  parameter logic [ATTR_W-1:0]  LIMIAR_SONO = 8'd10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_comer_i,
  input  logic              req_dormir_i,
  input  logic              req_aula_i,
  input  logic              req_reviver_i,
  input  logic [ATTR_W-1:0] fome_i,
  input  logic [ATTR_W-1:0] felicidade_i,
  input  logic [ATTR_W-1:0] sono_i,
  output logic [3:0]        estado_o,
  output logic              ocupado_o,
  output logic              pendente_o,
  output logic              aceito_o,
  output logic              reiniciar_o
);

  localparam int TW = $clog2(DURACAO);
  localparam logic [TW-1:0] T_INI = TW'(DURACAO - 1);

  typedef enum logic [3:0] {
    OCIOSO     = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;

  estado_t       estado_q, buf_q, sel;
  logic [TW-1:0] timer_q;
  logic          pendente_q, aceito_q, reiniciar_q;
  logic          morte;

  // Fixed priority comer > dormir > aula; OCIOSO means no request this cycle.
  always_comb begin
    sel = OCIOSO;
    if (req_comer_i)       sel = COMENDO;
    else if (req_dormir_i) sel = DORMINDO;
    else if (req_aula_i)   sel = DANDO_AULA;
  end

  assign morte = (fome_i == '0) || (felicidade_i == '0) || (sono_i == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q    <= OCIOSO;
      buf_q       <= OCIOSO;
      timer_q     <= '0;
      pendente_q  <= 1'b0;
      aceito_q    <= 1'b0;
      reiniciar_q <= 1'b0;
    end else begin
      aceito_q    <= 1'b0;
      reiniciar_q <= 1'b0;
      if (estado_q == MORTO) begin
        if (req_reviver_i) begin
          estado_q    <= OCIOSO;
          reiniciar_q <= 1'b1;
        end
      end else if (morte) begin
        estado_q   <= MORTO;
        buf_q      <= OCIOSO;
        timer_q    <= '0;
        pendente_q <= 1'b0;
      end else if (estado_q == OCIOSO) begin
        if (sel != OCIOSO) begin
          estado_q <= sel;
          timer_q  <= T_INI;
          aceito_q <= 1'b1;
        end else if (sono_i <= LIMIAR_SONO) begin
          estado_q <= DORMINDO;
          timer_q  <= T_INI;
          aceito_q <= 1'b1;
        end
      end else if (timer_q == '0) begin
        // Action ends: buffered request first, then a fresh one, else idle.
        if (pendente_q) begin
          estado_q   <= buf_q;
          timer_q    <= T_INI;
          aceito_q   <= 1'b1;
          buf_q      <= OCIOSO;
          pendente_q <= 1'b0;
        end else if (sel != OCIOSO) begin
          estado_q <= sel;
          timer_q  <= T_INI;
          aceito_q <= 1'b1;
        end else begin
          estado_q <= OCIOSO;
        end
      end else begin
        timer_q <= timer_q - 1'b1;
        if (!pendente_q && sel != OCIOSO) begin
          buf_q      <= sel;
          pendente_q <= 1'b1;
        end
      end
    end
  end

  assign estado_o    = estado_q;
  assign ocupado_o   = |estado_q[2:0];
  assign pendente_o  = pendente_q;
  assign aceito_o    = aceito_q;
  assign reiniciar_o = reiniciar_q;

endmodule

// File: tb/tb_escalonador_acoes.sv
// Bench for escalonador_acoes: directed scenarios plus random traffic, every cycle
// compared against an action/remaining-cycles/queue model of the pet.
module tb_escalonador_acoes;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, req_comer, req_dormir, req_aula, req_reviver;
  logic [7:0] fome, felicidade, sono;
  logic [3:0] estado;
  logic       ocupado, pendente, aceito, reiniciar;

  always #5 clk = ~clk;

  escalonador_acoes #(.DURACAO(D), .ATTR_W(8), .LIMIAR_SONO(8'd10)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_comer_i(req_comer), .req_dormir_i(req_dormir), .req_aula_i(req_aula),
    .req_reviver_i(req_reviver),
    .fome_i(fome), .felicidade_i(felicidade), .sono_i(sono),
    .estado_o(estado), .ocupado_o(ocupado), .pendente_o(pendente),
    .aceito_o(aceito), .reiniciar_o(reiniciar)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Model: activity name, cycles still to show, and a one-entry wait list.
  localparam int IDLE = 0, SLEEP = 1, EAT = 2, TEACH = 3, DEAD = 4;
  int m_act = IDLE;
  int m_rem = 0;
  int m_q[$];
  bit m_acc, m_rei;

  function automatic logic [3:0] onehot(input int a);
    case (a)
      SLEEP:   return 4'b0001;
      EAT:     return 4'b0010;
      TEACH:   return 4'b0100;
      DEAD:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic start(input int a);
    m_act = a;
    m_rem = D;
    m_acc = 1'b1;
  endtask

  task automatic model_step();
    int pick;
    m_acc = 1'b0;
    m_rei = 1'b0;
    pick = req_comer ? EAT : req_dormir ? SLEEP : req_aula ? TEACH : IDLE;
    if (rst) begin
      m_act = IDLE; m_rem = 0; m_q.delete();
    end else if (m_act == DEAD) begin
      if (req_reviver) begin m_act = IDLE; m_rei = 1'b1; end
    end else if (fome == 0 || felicidade == 0 || sono == 0) begin
      m_act = DEAD; m_rem = 0; m_q.delete();
    end else if (m_act == IDLE) begin
      if (pick != IDLE) start(pick);
      else if (sono <= 10) start(SLEEP);
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_q.size() > 0) start(m_q.pop_front());
        else if (pick != IDLE) start(pick);
        else m_act = IDLE;
      end else if (m_q.size() == 0 && pick != IDLE) begin
        m_q.push_back(pick);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit s, input bit a, input bit v,
                     input logic [7:0] fo, input logic [7:0] fe, input logic [7:0] so);
    @(negedge clk);
    rst = r; req_comer = c; req_dormir = s; req_aula = a; req_reviver = v;
    fome = fo; felicidade = fe; sono = so;
    model_step();
    @(posedge clk);
    #1;
    chk("estado",    32'(estado),    32'(onehot(m_act)));
    chk("ocupado",   32'(ocupado),   32'(m_act inside {SLEEP, EAT, TEACH}));
    chk("pendente",  32'(pendente),  32'(m_q.size() != 0));
    chk("aceito",    32'(aceito),    32'(m_acc));
    chk("reiniciar", 32'(reiniciar), 32'(m_rei));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 50, 50, 50);
  endtask

  initial begin
    rst = 1; req_comer = 0; req_dormir = 0; req_aula = 0; req_reviver = 0;
    fome = 50; felicidade = 50; sono = 50;

    // Reset
    cyc(1, 0, 0, 0, 0, 50, 50, 50);
    cyc(1, 0, 0, 0, 0, 50, 50, 50);
    chk("reset_estado", 32'(estado), 32'h0);

    // Single eat pulse, then all three at once
    cyc(0, 1, 0, 0, 0, 50, 50, 50);
    idle(5);
    cyc(0, 1, 1, 1, 0, 50, 50, 50);
    idle(5);

    // Teach, sleep buffered, eat dropped while buffer full
    cyc(0, 0, 0, 1, 0, 50, 50, 50);
    cyc(0, 0, 1, 0, 0, 50, 50, 50);
    cyc(0, 1, 0, 0, 0, 50, 50, 50);
    idle(9);

    // Death mid-sleep with a buffered request, ignored request, then revive
    cyc(0, 0, 1, 0, 0, 50, 50, 50);
    cyc(0, 0, 0, 1, 0, 50, 50, 50);
    cyc(0, 0, 0, 0, 0, 0, 50, 50);
    chk("morto", 32'(estado), 32'h8);
    cyc(0, 1, 0, 0, 0, 50, 50, 50);
    cyc(0, 0, 0, 0, 1, 50, 50, 50);
    chk("revive", 32'(reiniciar), 32'h1);
    idle(2);

    // Low sono forces sleep; reset mid-action
    cyc(0, 0, 0, 0, 0, 50, 50, 10);
    cyc(0, 0, 0, 0, 0, 50, 50, 50);
    cyc(1, 0, 0, 0, 0, 50, 50, 50);
    chk("rst_mid", 32'(estado), 32'h0);

    // Request in the cycle the action ends with an empty buffer
    cyc(0, 0, 0, 1, 0, 50, 50, 50);
    idle(3);
    cyc(0, 1, 0, 0, 0, 50, 50, 50);
    idle(5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] fo, fe, so;
      fo = ($urandom_range(0, 60) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      fe = ($urandom_range(0, 80) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      so = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(11, 255));
      cyc($urandom_range(0, 150) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 6) == 0, fo, fe, so);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
